stream_write: RTL and testbench

Write-side counterpart of the streaming read engine. It accepts a write request (start address, beat count), then takes 64-bit beats on a slave AXI-style W channel. It packs those beats into 512-bit, 64-byte lines and writes each line to memory as a single-beat AXI4 burst on the 512-bit master port. It sits between the accelerator's store stream and the shell DDR/PCIe AXI master.

---
 rtl/stream_pkg.sv | 38 +++
 rtl/stream_write_if.sv | 65 ++++++
 rtl/stream_write_line_buf.sv | 36 +++
 rtl/stream_write.sv | 177 +++++++++++++++++
 tb/tb_stream_write.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared types and constants for the streaming write engine.
package stream_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 64;
    localparam int unsigned LINE_W         = 512;
    localparam int unsigned ID_W           = 16;
    localparam int unsigned COUNT_W        = 9;

    localparam int unsigned LINE_BYTES     = 64;
    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned STRB_W         = DATA_W / 8;
    localparam int unsigned LINE_STRB_W    = LINE_W / 8;
    localparam int unsigned WORD_IDX_W     = 3;
    localparam int unsigned WORD_OFF_W     = 3;
    localparam int unsigned LINE_OFF_W     = 6;
    localparam int unsigned LINE_ADDR_W    = ADDR_W - LINE_OFF_W;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_AW,
        S_W,
        S_B,
        S_RESP
    } state_e;

endpackage

// File: rtl/stream_write_if.sv
// Request, 64-bit W/B slave channel and 512-bit AXI4 write master bundle.
// The master modport is the write engine; slave is whatever surrounds it.
interface stream_write_if;
    import stream_pkg::*;

    logic [ADDR_W-1:0]      req_addr;
    logic [COUNT_W-1:0]     req_burst_count;
    logic                   req_val;
    logic                   req_rdy;

    logic [DATA_W-1:0]      s_axi_wdata;
    logic [STRB_W-1:0]      s_axi_wstrb;
    logic                   s_axi_wvalid;
    logic                   s_axi_wready;
    logic [1:0]             s_axi_bresp;
    logic                   s_axi_bvalid;
    logic                   s_axi_bready;

    logic [ID_W-1:0]        m_axi_awid;
    logic [ADDR_W-1:0]      m_axi_awaddr;
    logic [7:0]             m_axi_awlen;
    logic [2:0]             m_axi_awsize;
    logic [1:0]             m_axi_awburst;
    logic                   m_axi_awlock;
    logic [3:0]             m_axi_awcache;
    logic [2:0]             m_axi_awprot;
    logic [3:0]             m_axi_awqos;
    logic [3:0]             m_axi_awregion;
    logic                   m_axi_awvalid;
    logic                   m_axi_awready;
    logic [LINE_W-1:0]      m_axi_wdata;
    logic [LINE_STRB_W-1:0] m_axi_wstrb;
    logic                   m_axi_wlast;
    logic                   m_axi_wvalid;
    logic                   m_axi_wready;
    logic [ID_W-1:0]        m_axi_bid;
    logic [1:0]             m_axi_bresp;
    logic                   m_axi_bvalid;
    logic                   m_axi_bready;

    modport master (
        input  req_addr, req_burst_count, req_val,
        output req_rdy,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
        output s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
        output m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        output req_addr, req_burst_count, req_val,
        input  req_rdy,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
        input  s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
        input  m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );

endinterface

// File: rtl/stream_write_line_buf.sv
// One 64-byte line being assembled: data words plus accumulated byte strobes.
module stream_write_line_buf
    import stream_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   wr_i,
    input  logic [WORD_IDX_W-1:0]  slot_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [STRB_W-1:0]      wstrb_i,
    output logic [LINE_W-1:0]      data_o,
    output logic [LINE_STRB_W-1:0] strb_o
);

    logic [LINE_W-1:0]      data_q;
    logic [LINE_STRB_W-1:0] strb_q;

    // Clear wipes the whole line; a write fills one word slot and its strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            strb_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            strb_q <= '0;
        end else if (wr_i) begin
            data_q[slot_i*DATA_W +: DATA_W] <= wdata_i;
            strb_q[slot_i*STRB_W +: STRB_W] <= wstrb_i;
        end
    end

    assign data_o = data_q;
    assign strb_o = strb_q;

endmodule

// File: rtl/stream_write.sv
// Packs 64-bit store beats into 64-byte lines and writes each line as a
// single-beat AXI4 burst. Define STREAM_WRITE_WSTRB_EN to honour per-byte
// s_axi_wstrb; otherwise every accepted beat writes all eight bytes.
module stream_write
    import stream_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    stream_write_if.master bus
);

    state_e                  state_q, state_d;
    logic [LINE_ADDR_W-1:0]  line_addr_q, line_addr_d;
    logic [WORD_IDX_W-1:0]   k_q, k_d;
    logic [COUNT_W-1:0]      remain_q, remain_d;
    logic [1:0]              resp_q, resp_d;
    logic                    req_rdy_q, req_rdy_d;
    logic                    wready_q, wready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    bvalid_q, bvalid_d;

    logic                    buf_clr_c;
    logic                    buf_wr_c;
    logic [STRB_W-1:0]       beat_strb_c;
    logic [LINE_W-1:0]       line_data;
    logic [LINE_STRB_W-1:0]  line_strb;
    logic                    unused_c;

`ifdef STREAM_WRITE_WSTRB_EN
    assign beat_strb_c = bus.s_axi_wstrb;
`else
    assign beat_strb_c = '1;
`endif

    assign unused_c = ^{bus.s_axi_wstrb, bus.m_axi_bid, bus.req_addr[WORD_OFF_W-1:0]};

    stream_write_line_buf u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (buf_clr_c),
        .wr_i    (buf_wr_c),
        .slot_i  (k_q),
        .wdata_i (bus.s_axi_wdata),
        .wstrb_i (beat_strb_c),
        .data_o  (line_data),
        .strb_o  (line_strb)
    );

    // State, counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            line_addr_q <= '0;
            k_q         <= '0;
            remain_q    <= '0;
            resp_q      <= OKAY;
            req_rdy_q   <= 1'b1;
            wready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            k_q         <= k_d;
            remain_q    <= remain_d;
            resp_q      <= resp_d;
            req_rdy_q   <= req_rdy_d;
            wready_q    <= wready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            bvalid_q    <= bvalid_d;
        end
    end

    // Next-state logic; handshake outputs are decoded from the next state.
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        k_d         = k_q;
        remain_d    = remain_q;
        resp_d      = resp_q;
        buf_clr_c   = 1'b0;
        buf_wr_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_val && req_rdy_q) begin
                    line_addr_d = bus.req_addr[ADDR_W-1:LINE_OFF_W];
                    k_d         = bus.req_addr[LINE_OFF_W-1:WORD_OFF_W];
                    remain_d    = bus.req_burst_count;
                    resp_d      = OKAY;
                    state_d     = (bus.req_burst_count == '0) ? S_RESP : S_FILL;
                end
            end
            S_FILL: begin
                if (bus.s_axi_wvalid && wready_q) begin
                    buf_wr_c = 1'b1;
                    k_d      = k_q + WORD_IDX_W'(1);
                    remain_d = remain_q - COUNT_W'(1);
                    if ((k_q == WORD_IDX_W'(WORDS_PER_LINE - 1)) || (remain_q == COUNT_W'(1))) begin
                        state_d = S_AW;
                    end
                end
            end
            S_AW: begin
                if (bus.m_axi_awready && awvalid_q) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (bus.m_axi_wready && wvalid_q) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bus.m_axi_bvalid && bready_q) begin
                    if (bus.m_axi_bresp > resp_q) begin
                        resp_d = bus.m_axi_bresp;
                    end
                    buf_clr_c = 1'b1;
                    if (remain_q != '0) begin
                        line_addr_d = line_addr_q + LINE_ADDR_W'(1);
                        k_d         = '0;
                        state_d     = S_FILL;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.s_axi_bready && bvalid_q) begin
                    resp_d  = OKAY;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_rdy_d = (state_d == S_IDLE);
        wready_d  = (state_d == S_FILL);
        awvalid_d = (state_d == S_AW);
        wvalid_d  = (state_d == S_W);
        bready_d  = (state_d == S_B);
        bvalid_d  = (state_d == S_RESP);
    end

    assign bus.req_rdy        = req_rdy_q;
    assign bus.s_axi_wready   = wready_q;
    assign bus.s_axi_bresp    = resp_q;
    assign bus.s_axi_bvalid   = bvalid_q;

    assign bus.m_axi_awid     = '0;
    assign bus.m_axi_awaddr   = {line_addr_q, {LINE_OFF_W{1'b0}}};
    assign bus.m_axi_awlen    = 8'd0;
    assign bus.m_axi_awsize   = AXI_SIZE_64B;
    assign bus.m_axi_awburst  = AXI_BURST_INCR;
    assign bus.m_axi_awlock   = 1'b0;
    assign bus.m_axi_awcache  = 4'd0;
    assign bus.m_axi_awprot   = 3'd0;
    assign bus.m_axi_awqos    = 4'd0;
    assign bus.m_axi_awregion = 4'd0;
    assign bus.m_axi_awvalid  = awvalid_q;

    assign bus.m_axi_wdata    = line_data;
    assign bus.m_axi_wstrb    = line_strb;
    assign bus.m_axi_wlast    = 1'b1;
    assign bus.m_axi_wvalid   = wvalid_q;
    assign bus.m_axi_bready   = bready_q;

endmodule

// File: tb/tb_stream_write.sv
// Scoreboard bench for stream_write: expected lines and responses are queued
// by the stimulus; a monitor pops them as the DUT presents handshakes.
module tb_stream_write;
    import stream_pkg::*;

    localparam int TMO = 2000;

    typedef struct {
        logic [ADDR_W-1:0]      addr;
        logic [LINE_W-1:0]      data;
        logic [LINE_STRB_W-1:0] strb;
    } line_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_write_if bus ();

    stream_write dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    line_t             exp_lines[$];
    logic [1:0]        exp_resp[$];
    logic [1:0]        bresp_plan[$];
    logic [DATA_W-1:0] beats[$];
    logic [STRB_W-1:0] strbs[$];

    int tests    = 0;
    int fails    = 0;
    int aw_count = 0;
    int stall    = 0;

    int   aw_wait = 0;
    int   w_wait  = 0;
    logic w_fire  = 1'b0;

    logic                   aw_pend = 1'b0;
    logic                   w_pend  = 1'b0;
    logic [ADDR_W-1:0]      aw_prev;
    logic [LINE_W-1:0]      wd_prev;
    logic [LINE_STRB_W-1:0] ws_prev;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out after %0d cycles", name, TMO);
    endtask

    function automatic logic [DATA_W-1:0] beat_val(input int tag, input int i);
        return {16'hBEEF, 16'(tag), 32'(i)};
    endfunction

    task automatic fill_beats(input int tag, input int n, input logic [STRB_W-1:0] s);
        beats.delete();
        strbs.delete();
        for (int i = 0; i < n; i++) begin
            beats.push_back(beat_val(tag, i));
            strbs.push_back(s);
        end
    endtask

    task automatic push_line(input logic [ADDR_W-1:0] addr, input logic [LINE_STRB_W-1:0] strb,
                             input int first, input int slot0, input int n);
        line_t l;
        l.addr = addr;
        l.strb = strb;
        l.data = '0;
        for (int j = 0; j < n; j++) begin
            l.data[(slot0 + j)*DATA_W +: DATA_W] = beats[first + j];
        end
        exp_lines.push_back(l);
    endtask

    task automatic drive_req(input logic [ADDR_W-1:0] addr, input logic [COUNT_W-1:0] cnt);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_addr        = addr;
        bus.req_burst_count = cnt;
        bus.req_val         = 1'b1;
        while (!bus.req_rdy && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) timeout_fail("req_accept");
        @(negedge clk);
        bus.req_val = 1'b0;
    endtask

    task automatic drive_beats(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            bus.s_axi_wdata  = beats[i];
            bus.s_axi_wstrb  = strbs[i];
            bus.s_axi_wvalid = 1'b1;
            w = 0;
            while (!bus.s_axi_wready && w < TMO) begin
                @(negedge clk);
                w++;
            end
            if (w >= TMO) begin
                timeout_fail("beat_accept");
                break;
            end
            @(negedge clk);
        end
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || exp_lines.size() != 0) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) timeout_fail(name);
        repeat (2) @(negedge clk);
    endtask

    // Memory side: AW/W ready after `stall` cycles, one B pulse per line.
    initial begin
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = OKAY;
        bus.m_axi_bid     = '0;
        forever begin
            @(negedge clk);
            if (w_fire) begin
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp  = OKAY;
                if (bresp_plan.size() != 0) bus.m_axi_bresp = bresp_plan.pop_front();
                check("bready_with_bvalid", LINE_W'(bus.m_axi_bready), LINE_W'(1));
            end else begin
                bus.m_axi_bvalid = 1'b0;
            end
            if (bus.m_axi_awvalid) begin
                if (aw_wait < stall) begin
                    aw_wait++;
                    bus.m_axi_awready = 1'b0;
                end else begin
                    bus.m_axi_awready = 1'b1;
                end
            end else begin
                bus.m_axi_awready = 1'b0;
                aw_wait = 0;
            end
            if (bus.m_axi_wvalid) begin
                if (w_wait < stall) begin
                    w_wait++;
                    bus.m_axi_wready = 1'b0;
                end else begin
                    bus.m_axi_wready = 1'b1;
                end
            end else begin
                bus.m_axi_wready = 1'b0;
                w_wait = 0;
            end
            w_fire = bus.m_axi_wvalid && bus.m_axi_wready;
        end
    end

    // Monitor: checks every handshake against the scoreboard queues.
    initial begin
        line_t l;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                aw_pend = 1'b0;
                w_pend  = 1'b0;
                continue;
            end
            if (aw_pend) begin
                check("awvalid_held", LINE_W'(bus.m_axi_awvalid), LINE_W'(1));
                check("awaddr_stable", LINE_W'(bus.m_axi_awaddr), LINE_W'(aw_prev));
            end
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                aw_count++;
                if (exp_lines.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL aw_unexpected: awaddr %0h with no line expected", bus.m_axi_awaddr);
                end else begin
                    check("awaddr", LINE_W'(bus.m_axi_awaddr), LINE_W'(exp_lines[0].addr));
                    check("aw_len_size_burst",
                          LINE_W'({bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst}),
                          LINE_W'({8'd0, 3'b110, 2'b01}));
                    check("aw_zero_fields",
                          LINE_W'({bus.m_axi_awid, bus.m_axi_awlock, bus.m_axi_awcache,
                                   bus.m_axi_awprot, bus.m_axi_awqos, bus.m_axi_awregion}),
                          LINE_W'(0));
                end
            end
            aw_pend = bus.m_axi_awvalid && !bus.m_axi_awready;
            aw_prev = bus.m_axi_awaddr;

            if (w_pend) begin
                check("wvalid_held", LINE_W'(bus.m_axi_wvalid), LINE_W'(1));
                check("wdata_stable", bus.m_axi_wdata, wd_prev);
                check("wstrb_stable", LINE_W'(bus.m_axi_wstrb), LINE_W'(ws_prev));
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                if (exp_lines.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL w_unexpected: wstrb %0h with no line expected", bus.m_axi_wstrb);
                end else begin
                    l = exp_lines.pop_front();
                    check("wdata", bus.m_axi_wdata, l.data);
                    check("wstrb", LINE_W'(bus.m_axi_wstrb), LINE_W'(l.strb));
                    check("wlast", LINE_W'(bus.m_axi_wlast), LINE_W'(1));
                end
            end
            w_pend  = bus.m_axi_wvalid && !bus.m_axi_wready;
            wd_prev = bus.m_axi_wdata;
            ws_prev = bus.m_axi_wstrb;

            if (bus.s_axi_bvalid && bus.s_axi_bready) begin
                if (exp_resp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL s_b_unexpected: bresp %0h with no response expected", bus.s_axi_bresp);
                end else begin
                    check("s_axi_bresp", LINE_W'(bus.s_axi_bresp), LINE_W'(exp_resp.pop_front()));
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int aw_before;
        logic [LINE_STRB_W-1:0] strb_exp;

        bus.req_addr        = '0;
        bus.req_burst_count = '0;
        bus.req_val         = 1'b0;
        bus.s_axi_wdata     = '0;
        bus.s_axi_wstrb     = '0;
        bus.s_axi_wvalid    = 1'b0;
        bus.s_axi_bready    = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_rdy", LINE_W'(bus.req_rdy), LINE_W'(1));
        check("rst_s_wready", LINE_W'(bus.s_axi_wready), LINE_W'(0));
        check("rst_s_bvalid", LINE_W'(bus.s_axi_bvalid), LINE_W'(0));
        check("rst_s_bresp", LINE_W'(bus.s_axi_bresp), LINE_W'(0));
        check("rst_m_valids", LINE_W'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}), LINE_W'(0));
        check("rst_line_buf", bus.m_axi_wdata, LINE_W'(0));
        check("rst_line_strb", LINE_W'(bus.m_axi_wstrb), LINE_W'(0));

        // Single beat 0xAA at address 0.
        beats.delete();
        strbs.delete();
        beats.push_back(64'hAA);
        strbs.push_back(8'hFF);
        push_line(32'h0, 64'hFF, 0, 0, 1);
        exp_resp.push_back(OKAY);
        drive_req(32'h0, 9'd1);
        drive_beats(1);
        wait_done("single_beat");

        // Nine beats: one full line then one word.
        fill_beats(2, 9, 8'hFF);
        push_line(32'h0, '1, 0, 0, 8);
        push_line(32'h40, 64'hFF, 8, 0, 1);
        exp_resp.push_back(OKAY);
        drive_req(32'h0, 9'd9);
        drive_beats(9);
        wait_done("nine_beats");

        // Unaligned start 0x830, 17 beats over three lines.
        fill_beats(3, 17, 8'hFF);
        push_line(32'h800, 64'hFFFF_0000_0000_0000, 0, 6, 2);
        push_line(32'h840, '1, 2, 0, 8);
        push_line(32'h880, 64'h00FF_FFFF_FFFF_FFFF, 10, 0, 7);
        exp_resp.push_back(OKAY);
        drive_req(32'h830, 9'd17);
        drive_beats(17);
        wait_done("unaligned");

        // SLVERR on the middle line sticks through the third line.
        fill_beats(4, 24, 8'hFF);
        push_line(32'h1000, '1, 0, 0, 8);
        push_line(32'h1040, '1, 8, 0, 8);
        push_line(32'h1080, '1, 16, 0, 8);
        bresp_plan.push_back(OKAY);
        bresp_plan.push_back(SLVERR);
        bresp_plan.push_back(OKAY);
        exp_resp.push_back(SLVERR);
        drive_req(32'h1000, 9'd24);
        drive_beats(24);
        wait_done("slverr_sticky");

        // Memory holds awready/wready low for 10 cycles.
        stall = 10;
        fill_beats(5, 8, 8'hFF);
        push_line(32'h2000, '1, 0, 0, 8);
        exp_resp.push_back(OKAY);
        drive_req(32'h2000, 9'd8);
        drive_beats(8);
        wait_done("stall");
        stall = 0;

        // Zero count: response only, no memory traffic.
        aw_before = aw_count;
        exp_resp.push_back(OKAY);
        drive_req(32'h5000, 9'd0);
        wait_done("count_zero");
        check("count0_no_aw", LINE_W'(aw_count), LINE_W'(aw_before));

        // Partial byte strobe on one beat.
`ifdef STREAM_WRITE_WSTRB_EN
        strb_exp = 64'h0F;
`else
        strb_exp = 64'hFF;
`endif
        fill_beats(7, 1, 8'h0F);
        push_line(32'h3000, strb_exp, 0, 0, 1);
        exp_resp.push_back(OKAY);
        drive_req(32'h3000, 9'd1);
        drive_beats(1);
        wait_done("wstrb");

        // Address wrap at 2^32.
        fill_beats(8, 2, 8'hFF);
        push_line(32'hFFFF_FFC0, 64'hFF00_0000_0000_0000, 0, 7, 1);
        push_line(32'h0, 64'hFF, 1, 0, 1);
        exp_resp.push_back(OKAY);
        drive_req(32'hFFFF_FFF8, 9'd2);
        drive_beats(2);
        wait_done("addr_wrap");

        // Reset in the middle of filling a line drops it.
        aw_before = aw_count;
        fill_beats(9, 8, 8'hFF);
        drive_req(32'h4000, 9'd8);
        drive_beats(3);
        rst_n = 1'b0;
        #1;
        check("midrst_req_rdy", LINE_W'(bus.req_rdy), LINE_W'(1));
        check("midrst_valids",
              LINE_W'({bus.s_axi_wready, bus.s_axi_bvalid, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}),
              LINE_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_aw", LINE_W'(aw_count), LINE_W'(aw_before));

        // Engine works normally after the reset.
        fill_beats(10, 1, 8'hFF);
        push_line(32'h40, 64'hFF_0000, 0, 2, 1);
        exp_resp.push_back(OKAY);
        drive_req(32'h50, 9'd1);
        drive_beats(1);
        wait_done("after_reset");

        check("lines_drained", LINE_W'(exp_lines.size()), LINE_W'(0));
        check("resp_drained", LINE_W'(exp_resp.size()), LINE_W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
